// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core constants and memory arbiter types
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } arb_state_e;

    typedef enum logic {
        ARB_I,
        ARB_D
    } arb_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-outstanding arbiter of instruction and data ports onto one memory
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int StarveLimit   = 3,
    parameter int TimeoutCycles = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            i_req_i,
    input  logic [XLEN-1:0] i_addr_i,
    output logic            i_gnt_o,
    output logic            i_rvalid_o,
    output logic [XLEN-1:0] i_rdata_o,
    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [3:0]      d_be_i,
    input  logic [XLEN-1:0] d_addr_i,
    input  logic [XLEN-1:0] d_wdata_i,
    output logic            d_gnt_o,
    output logic            d_rvalid_o,
    output logic [XLEN-1:0] d_rdata_o,
    output logic            m_req_o,
    output logic            m_we_o,
    output logic [3:0]      m_be_o,
    output logic [XLEN-1:0] m_addr_o,
    output logic [XLEN-1:0] m_wdata_o,
    input  logic            m_gnt_i,
    input  logic            m_rvalid_i,
    input  logic [XLEN-1:0] m_rdata_i,
    output logic            err_o,
    output logic            busy_o
);

    arb_state_e state, stateNext;
    arb_owner_e owner, ownerNext;
    logic [3:0]  starveCnt, starveNext;
    logic [15:0] tmoCnt, tmoNext;
    logic        ownD, gnt, rsp, tmo;

    // State, owner and both counters; reset abandons any transaction in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            owner     <= ARB_I;
            starveCnt <= '0;
            tmoCnt    <= '0;
        end else begin
            state     <= stateNext;
            owner     <= ownerNext;
            starveCnt <= starveNext;
            tmoCnt    <= tmoNext;
        end
    end

    // Arbitration, grant handshake, response/timeout sequencing
    always_comb begin
        stateNext  = state;
        ownerNext  = owner;
        starveNext = starveCnt;
        tmoNext    = tmoCnt;
        gnt        = 1'b0;
        rsp        = 1'b0;
        tmo        = 1'b0;
        case (state)
            IDLE: if (i_req_i || d_req_i) begin
                ownerNext = (d_req_i && !(i_req_i && starveCnt == 4'(StarveLimit))) ? ARB_D : ARB_I;
                stateNext = REQ;
            end
            REQ: if (m_gnt_i) begin
                gnt        = 1'b1;
                stateNext  = WAIT;
                tmoNext    = '0;
                starveNext = (owner == ARB_D && i_req_i) ? ((starveCnt == 4'hF) ? starveCnt : starveCnt + 4'd1) : '0;
            end
            WAIT: if (m_rvalid_i) begin
                rsp       = 1'b1;
                stateNext = IDLE;
            end else if (tmoCnt == 16'(TimeoutCycles - 1)) begin
                rsp       = 1'b1;
                tmo       = 1'b1;
                stateNext = IDLE;
            end else begin
                tmoNext = tmoCnt + 16'd1;
            end
            default: stateNext = IDLE;
        endcase
    end

    // The memory bundle follows the owner's live inputs and is zero outside REQ
    assign ownD      = owner == ARB_D;
    assign m_req_o   = state == REQ;
    assign m_we_o    = m_req_o && ownD && d_we_i;
    assign m_be_o    = !m_req_o ? 4'h0 : ownD ? d_be_i : 4'hF;
    assign m_addr_o  = !m_req_o ? '0 : ownD ? d_addr_i : i_addr_i;
    assign m_wdata_o = (m_req_o && ownD) ? d_wdata_i : '0;

    assign i_gnt_o    = gnt && !ownD;
    assign d_gnt_o    = gnt && ownD;
    assign i_rvalid_o = rsp && !ownD;
    assign d_rvalid_o = rsp && ownD;
    assign i_rdata_o  = (i_rvalid_o && !tmo) ? m_rdata_i : '0;
    assign d_rdata_o  = (d_rvalid_o && !tmo) ? m_rdata_i : '0;
    assign err_o      = tmo;
    assign busy_o     = state != IDLE;

endmodule
